nios_128k_base_led: RTL and testbench



---
 rtl/nios_128k_base_led_pkg.sv | 22 ++
 rtl/nios_128k_base_led_blink.sv | 57 +++++
 rtl/nios_128k_base_led.sv | 109 ++++++++++
 tb/tb_nios_128k_base_led.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_128k_base_led_pkg.sv
// rtl/nios_128k_base_led_pkg.sv - register map constants shared by the LED PIO
//
// Purpose: word addresses of the LED PIO registers and the STATUS layout.
// Ports:   none (package).

package nios_128k_base_led_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    // Bit of STATUS that carries the blink phase.
    localparam int STATUS_PHASE_BIT = 31;

    function automatic logic bus_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/nios_128k_base_led_blink.sv
// rtl/nios_128k_base_led_blink.sv - blink down-counter and phase flop
//
// Purpose: free-running prescaler; phase toggles every period+1 cycles.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   period        reload value (already the new value in a load cycle)
//   load          PERIOD register written this cycle: restart counter, clear phase
//   counter       current down-counter value
//   phase         blink phase, toggles on each reload

module nios_128k_base_led_blink #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic [PERIOD_W-1:0] counter,
    output logic                phase
);

    logic [PERIOD_W-1:0] counter_q, counter_d;
    logic                phase_q, phase_d;

    always_comb begin
        counter_d = counter_q;
        phase_d   = phase_q;
        if (load) begin
            // A PERIOD write takes priority over a coincident expiry.
            counter_d = period;
            phase_d   = 1'b0;
        end else if (period == '0) begin
            counter_d = '0;
            phase_d   = 1'b0;
        end else if (counter_q == '0) begin
            // Reload rather than decrement: the counter never wraps.
            counter_d = period;
            phase_d   = ~phase_q;
        end else begin
            counter_d = counter_q - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            phase_q   <= phase_d;
        end
    end

    assign counter = counter_q;
    assign phase   = phase_q;

endmodule

// File: rtl/nios_128k_base_led.sv
// rtl/nios_128k_base_led.sv - Avalon-MM LED output PIO with set/clear and blink
//
// Purpose: zero-wait-state register slave driving board LEDs.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     Avalon-MM slave write/address side
//   readdata               registered read data, 1-cycle latency
//   out_port               LED drive: data XOR (blink_mask AND phase)

module nios_128k_base_led
    import nios_128k_base_led_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       PERIOD_W    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                we;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_load;
    logic [31:0]         readdata_q, readdata_d;
    logic [PERIOD_W-1:0] counter;
    logic                phase;

    // Upper writedata bits are architecturally ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign we    = bus_write(chipselect, write_n);
    assign wdata = writedata[WIDTH-1:0];

    always_comb begin
        data_d      = data_q;
        mask_d      = mask_q;
        period_d    = period_q;
        period_load = 1'b0;
        if (we) begin
            case (address)
                ADDR_DATA:     data_d = wdata;
                ADDR_MASK:     mask_d = wdata;
                ADDR_PERIOD: begin
                    period_d    = writedata[PERIOD_W-1:0];
                    period_load = 1'b1;
                end
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    // Read mux is sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d[WIDTH-1:0]    = data_q;
            ADDR_MASK:   readdata_d[WIDTH-1:0]    = mask_q;
            ADDR_PERIOD: readdata_d[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata_d[PERIOD_W-1:0]     = counter;
                readdata_d[STATUS_PHASE_BIT] = phase;
            end
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            period_q   <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
        end
    end

    // period_d equals period_q except in a load cycle, where it is the new value.
    nios_128k_base_led_blink #(
        .PERIOD_W (PERIOD_W)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (period_load),
        .counter (counter),
        .phase   (phase)
    );

    assign readdata = readdata_q;
    assign out_port = data_q ^ (mask_q & {WIDTH{phase}});

endmodule

// File: tb/tb_nios_128k_base_led.sv
// tb/tb_nios_128k_base_led.sv - self-checking bench for the LED PIO

module tb_nios_128k_base_led;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_fail   = 0;

    nios_128k_base_led #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PERIOD_W    (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Count of rising edges so far; the model derives blink state from it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents plus the edge at which PERIOD was loaded.
    logic [7:0]  m_data   = 8'hA5;
    logic [7:0]  m_mask   = 8'h00;
    logic [23:0] m_period = 24'd0;
    int          t_load   = 0;

    function automatic logic [23:0] m_counter();
        int p, k;
        if (m_period == 24'd0) return 24'd0;
        p = int'(m_period);
        k = cyc - t_load;
        return 24'(p - (k % (p + 1)));
    endfunction

    function automatic logic m_phase();
        int p, k;
        if (m_period == 24'd0) return 1'b0;
        p = int'(m_period);
        k = cyc - t_load;
        return ((k / (p + 1)) % 2) == 1;
    endfunction

    function automatic logic [7:0] m_out();
        return m_data ^ (m_mask & {8{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return {24'd0, m_mask};
            3'd2: return {8'd0, m_period};
            3'd3: return {m_phase(), 7'd0, m_counter()};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_reset();
        m_data   = 8'hA5;
        m_mask   = 8'h00;
        m_period = 24'd0;
    endfunction

    // Drivers: called at a falling edge, return at the next falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        case (a)
            3'd0: m_data = d[7:0];
            3'd1: m_mask = d[7:0];
            3'd2: begin m_period = d[23:0]; t_load = cyc + 1; end
            3'd4: m_data = m_data | d[7:0];
            3'd5: m_data = m_data & ~d[7:0];
            default: ;
        endcase
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp        = m_read(a);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_out_port: got %h want a5", out_port);
        end
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %h want 0", readdata);
        end
        reset_n = 1'b1;
        m_reset();
        rd(3'd0, exp);
        n_checks++;
        if (readdata !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL reset_read_data: got %h want 000000a5", readdata);
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] exp;
        logic [7:0] want [3] = '{8'h3C, 8'hBD, 8'hB1};
        logic [2:0] adr  [3] = '{3'd0, 3'd4, 3'd5};
        logic [7:0] val  [3] = '{8'h3C, 8'h81, 8'h0C};
        for (int i = 0; i < 3; i++) begin
            wr(adr[i], {24'hFFFFFF, val[i]});
            n_checks++;
            if (out_port !== want[i]) begin
                n_fail++;
                $display("FAIL set_clear_%0d: out_port got %h want %h", i, out_port, want[i]);
            end
        end
        rd(3'd0, exp);
        n_checks++;
        if (readdata !== 32'h0000_00B1) begin
            n_fail++;
            $display("FAIL set_clear_read: got %h want 000000b1", readdata);
        end
        rd(3'd4, exp);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL outset_read: got %h want 0", readdata);
        end
    endtask

    task automatic test_blink();
        logic [31:0] exp;
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'h00);
        wr(3'd2, 32'd3);
        for (int i = 0; i < 16; i++) begin
            // Fixed expectation for PERIOD=3: four cycles per half-period.
            n_checks++;
            if (out_port !== (((i / 4) % 2) == 1 ? 8'h0F : 8'h00)) begin
                n_fail++;
                $display("FAIL blink_out_%0d: got %h", i, out_port);
            end
            rd(3'd3, exp);
            n_checks++;
            if (readdata !== {((i / 4) % 2) == 1, 7'd0, 24'(3 - (i % 4))}) begin
                n_fail++;
                $display("FAIL blink_status_%0d: got %h want %h", i, readdata, exp);
            end
        end
    endtask

    task automatic test_period_at_expiry();
        logic [31:0] exp;
        wr(3'd2, 32'd3);
        // State after edge k: k=7 is counter 0 with phase 1.
        repeat (7) idle();
        n_checks++;
        if (out_port !== 8'h0F) begin
            n_fail++;
            $display("FAIL expiry_pre: got %h want 0f", out_port);
        end
        wr(3'd2, 32'd5);
        for (int j = 0; j < 12; j++) begin
            n_checks++;
            if (out_port !== ((j >= 6) ? 8'h0F : 8'h00)) begin
                n_fail++;
                $display("FAIL expiry_out_%0d: got %h", j, out_port);
            end
            if (j == 0) begin
                rd(3'd3, exp);
                n_checks++;
                if (readdata !== 32'h0000_0005) begin
                    n_fail++;
                    $display("FAIL expiry_status: got %h want 00000005", readdata);
                end
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_stop_and_unused();
        logic [31:0] exp;
        wr(3'd0, 32'h5A);
        wr(3'd2, 32'd3);
        repeat (5) idle();
        n_checks++;
        if (out_port !== 8'h55) begin
            n_fail++;
            $display("FAIL stop_pre: got %h want 55", out_port);
        end
        wr(3'd2, 32'd0);
        for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (out_port !== 8'h5A) begin
                n_fail++;
                $display("FAIL stop_static_%0d: got %h want 5a", j, out_port);
            end
            idle();
        end
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), exp);
            n_checks++;
            if (readdata !== exp) begin
                n_fail++;
                $display("FAIL unused_read_a%0d: got %h want %h", a, readdata, exp);
            end
        end
        n_checks++;
        if (out_port !== 8'h5A) begin
            n_fail++;
            $display("FAIL unused_out: got %h want 5a", out_port);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp, d;
        logic [2:0]  a;
        int          op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 3);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd2) d = {d[31:24], 21'd0, d[2:0]};
            if (op == 0) begin
                wr(a, d);
            end else if (op == 1) begin
                rd(a, exp);
                n_checks++;
                if (readdata !== exp) begin
                    n_fail++;
                    $display("FAIL rand_read_%0d a%0d: got %h want %h", i, a, readdata, exp);
                end
            end else begin
                address = a;
                idle();
            end
            n_checks++;
            if (out_port !== m_out()) begin
                n_fail++;
                $display("FAIL rand_out_%0d: got %h want %h", i, out_port, m_out());
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        wr(3'd0, 32'h11);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'd2);
        address = 3'd3;
        repeat (4) idle();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_port !== 8'hA5) begin
            n_fail++;
            $display("FAIL async_out: got %h want a5", out_port);
        end
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_status: got %h want 0", readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        for (int j = 0; j < 12; j++) begin
            idle();
            n_checks++;
            if (out_port !== 8'hA5) begin
                n_fail++;
                $display("FAIL post_reset_out_%0d: got %h want a5", j, out_port);
            end
        end
        rd(3'd3, exp);
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_status: got %h want 0", readdata);
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_blink();
        test_period_at_expiry();
        test_stop_and_unused();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
